mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, wait-cycle limit for the timeout feature (4-bit counter range).
REQ-004 SHALL have ports, one per line:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- if_req  input  1  instruction-fetch refill request.
- if_addr  input  AW  fetch address.
- if_done  output  1  one-cycle fetch completion pulse.
- if_rdata  output  DW  fetch data, valid while if_done=1.
- dc_req  input  1  data-cache request.
- dc_we  input  1  1=write, 0=read.
- dc_addr  input  AW  data address.
- dc_wdata  input  DW  write data.
- dc_done  output  1  one-cycle data completion pulse.
- dc_rdata  output  DW  read data, valid while dc_done=1.
- mem_req  output  1  backing-memory request.
- mem_we  output  1  backing-memory write enable.
- mem_addr  output  AW  backing-memory address.
- mem_wdata  output  DW  backing-memory write data.
- mem_ready  input  1  memory accepts/completes the access this cycle.
- mem_rdata  input  DW  read data, valid with mem_ready.
- if_err, dc_err  output  1 each  timeout flag, valid with the matching done pulse.

Function
REQ-005 SHALL implement FSM states IDLE, MEM, DONE, all outputs registered.
REQ-006 IDLE: if any req=1 at a rising edge, SHALL latch owner, addr, we (0 for IF), and wdata, then enter MEM; otherwise stay in IDLE.
REQ-007 Arbitration: sole requester wins; if both request, SHALL grant the requester that is not last_owner (round-robin).
REQ-008 last_owner SHALL update on every grant.
REQ-009 MEM: mem_req=1, with mem_we/mem_addr/mem_wdata held stable from the latched values until mem_ready=1.
REQ-010 On the edge with mem_ready=1, SHALL capture mem_rdata and enter DONE.
REQ-011 DONE: SHALL assert exactly one of if_done/dc_done for one cycle, with matching rdata; SHALL drive rdata=0 for writes; SHALL then return to IDLE.
REQ-012 Latency with zero-wait memory: req sampled at edge k -> mem_req high in cycle k+1 -> done high in cycle k+2; each mem_ready wait cycle adds 1.
REQ-013 Requester SHALL hold req and operands until its done pulse, then drop req the following cycle unless issuing a new request; the arbiter never double-grants, since IDLE follows DONE.
REQ-014 Requests arriving in MEM/DONE SHALL be held pending, not lost, and arbitrated in the next IDLE.
REQ-015 mem_req SHALL be 0 in IDLE and DONE; back-to-back throughput is 1 access per 3 cycles minimum.
REQ-016 *_rdata SHALL hold the last value when done=0.

Reset
REQ-017 reset=1 at an edge SHALL force state=IDLE, last_owner=IF (first contention goes to DC), and all outputs and latched registers to 0.
REQ-018 Reset mid-MEM SHALL drop mem_req the following cycle, with no done pulse for the aborted access.

Configuration
REQ-019 Macro MEM_ARBITER_TIMEOUT_EN defined: a 4-bit counter clears on MEM entry and increments each MEM cycle with mem_ready=0.
REQ-020 With the macro defined, when the counter reaches TIMEOUT the block SHALL enter DONE, pulse done with err=1 and rdata=0, and drop mem_req.
REQ-021 Macro undefined: MEM waits indefinitely, and if_err/dc_err are tied 0.

Verification
REQ-022 Single IF read, mem_ready=1 immediately, mem_rdata=0x00000013 -> if_done at cycle k+2 with if_rdata=0x00000013, mem_we=0.
REQ-023 DC write dc_addr=0x100, dc_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_addr/mem_wdata stable 4 cycles, dc_done at k+5, dc_rdata=0.
REQ-024 if_req and dc_req both high continuously from reset -> grant order DC, IF, DC, IF; never two consecutive grants to one side.
REQ-025 reset asserted in the second MEM cycle -> mem_req=0 next cycle, no done pulse, next if_req served normally.
REQ-026 Timeout defined, TIMEOUT=15, mem_ready held 0 -> dc_done with dc_err=1 after 15 MEM cycles; timeout undefined -> mem_req stays 1 and no done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter sharing one backing memory between an instruction-fetch
//   refill port (IF, read-only) and a data-cache port (DC, read/write).
//   One access is in flight at a time: IDLE -> MEM -> DONE -> IDLE.
//   Contention between the two ports is resolved round-robin.
//
// Handshake (all ports): a requester raises *_req with stable operands and
//   holds both until its one-cycle *_done pulse; *_rdata and *_err are valid
//   while *_done=1, and *_rdata holds its last value otherwise. On the memory
//   side mem_req/mem_we/mem_addr/mem_wdata are held stable until the cycle in
//   which mem_ready=1 completes the access (mem_rdata is valid with it).
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   if_req/if_addr          fetch request in; if_done/if_rdata/if_err out
//   dc_req/dc_we/dc_addr/   data request in; dc_done/dc_rdata/dc_err out
//   dc_wdata
//   mem_req/mem_we/         memory request out
//   mem_addr/mem_wdata
//   mem_ready/mem_rdata     memory completion in
//   state_dbg               current FSM state (IDLE=0, MEM=1, DONE=2)
//
// Configuration
//   MEM_ARBITER_TIMEOUT_EN  when defined, an access that waits TIMEOUT MEM
//                           cycles without mem_ready completes with *_err=1
//                           and rdata=0. When undefined, MEM waits forever and
//                           if_err/dc_err are constant 0.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic [AW-1:0] dc_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic          dc_done,
  output logic [DW-1:0] dc_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_err,
  output logic          dc_err,
  output logic [1:0]    state_dbg
);

  // The wait counter is 4 bits wide, so only 1..15 is meaningful.
  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_t        state, state_next;
  logic          owner, owner_next;
  logic          last_owner, last_owner_next;
  logic          grant_dc;

  logic          mem_req_next, mem_we_next;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_wdata_next;
  logic          if_done_next, dc_done_next;
  logic [DW-1:0] if_rdata_next, dc_rdata_next;

  // Completion helpers shared by the normal and timeout exits of MEM.
  logic          finish;
  logic          finish_err;
  logic [DW-1:0] finish_rdata;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [3:0]    wait_cnt, wait_cnt_next;
  logic          if_err_next, dc_err_next;
`endif

  assign state_dbg = state;

  // Round-robin: DC wins if it is the only requester, or if both request
  // and IF was the last one served.
  assign grant_dc = dc_req && (!if_req || (last_owner == OWN_IF));

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    mem_req_next    = 1'b0;
    mem_we_next     = mem_we;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    if_done_next    = 1'b0;
    dc_done_next    = 1'b0;
    if_rdata_next   = if_rdata;
    dc_rdata_next   = dc_rdata;
    finish          = 1'b0;
    finish_err      = 1'b0;
    finish_rdata    = '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    wait_cnt_next   = wait_cnt;
    if_err_next     = 1'b0;
    dc_err_next     = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (if_req || dc_req) begin
          owner_next      = grant_dc;
          last_owner_next = grant_dc;
          mem_req_next    = 1'b1;
          mem_we_next     = grant_dc ? dc_we : 1'b0;
          mem_addr_next   = grant_dc ? dc_addr : if_addr;
          mem_wdata_next  = grant_dc ? dc_wdata : '0;
          state_next      = MEM;
`ifdef MEM_ARBITER_TIMEOUT_EN
          wait_cnt_next   = 4'd0;
`endif
        end
      end

      MEM: begin
        mem_req_next = 1'b1;
        if (mem_ready) begin
          finish       = 1'b1;
          finish_rdata = mem_we ? '0 : mem_rdata;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        // The cycle that would bring the count to TIMEOUT is the last wait.
        else if (wait_cnt + 4'd1 == 4'(TIMEOUT)) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 4'd1;
        end
`endif
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (finish) begin
      state_next   = DONE;
      mem_req_next = 1'b0;
      if (owner == OWN_DC) begin
        dc_done_next  = 1'b1;
        dc_rdata_next = finish_rdata;
      end else begin
        if_done_next  = 1'b1;
        if_rdata_next = finish_rdata;
      end
`ifdef MEM_ARBITER_TIMEOUT_EN
      if_err_next = finish_err && (owner == OWN_IF);
      dc_err_next = finish_err && (owner == OWN_DC);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      dc_done    <= 1'b0;
      if_rdata   <= '0;
      dc_rdata   <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      mem_req    <= mem_req_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      if_done    <= if_done_next;
      dc_done    <= dc_done_next;
      if_rdata   <= if_rdata_next;
      dc_rdata   <= dc_rdata_next;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      if_err   <= 1'b0;
      dc_err   <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      if_err   <= if_err_next;
      dc_err   <= dc_err_next;
    end
  end

  // finish_err only matters when the timeout path exists.
`else
  assign if_err = 1'b0;
  assign dc_err = 1'b0;

  logic unused_finish_err;
  assign unused_finish_err = finish_err;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level model (round-robin grant rule, an
// expected-rdata queue and per-port last-rdata tracking).
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          dc_done;
  logic [DW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          if_err;
  logic          dc_err;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_err(if_err), .dc_err(dc_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Advance through one rising edge; outputs are observed and inputs are
  // changed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    if_req = 1; dc_req = 1;      // requests during reset must be ignored
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({mem_req, mem_we, if_done, dc_done, if_err, dc_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, if_done, dc_done, if_err, dc_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dc_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h ifrd=%h dcrd=%h want all 0", mem_addr, mem_wdata, if_rdata, dc_rdata);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    clear_inputs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 32'h0000_0040;
    step();                                   // edge k samples the request
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL if_read_mem: got req=%b we=%b addr=%h want 1 0 00000040", mem_req, mem_we, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h0000_0013;
    step();                                   // cycle k+2
    checks++;
    if (if_done !== 1'b1 || dc_done !== 1'b0 || if_rdata !== 32'h13 || mem_req !== 1'b0 || if_err !== 1'b0) begin
      errors++;
      $display("FAIL if_read_done: got done=%b/%b rdata=%h mem_req=%b err=%b want 1/0 00000013 0 0",
               if_done, dc_done, if_rdata, mem_req, if_err);
    end
    if_req = 0; mem_ready = 0; mem_rdata = 32'hAAAA_5555;
    step();
    checks++;
    if (if_done !== 1'b0 || if_rdata !== 32'h13) begin
      errors++;
      $display("FAIL if_read_hold: got done=%b rdata=%h want 0 00000013", if_done, if_rdata);
    end
    step();
  endtask

  task automatic test_dc_write_wait();
    dc_req = 1; dc_we = 1; dc_addr = 32'h100; dc_wdata = 32'hDEAD_BEEF;
    step();                                   // edge k
    for (int i = 0; i < 4; i++) begin        // cycles k+1 .. k+4
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 ||
          mem_wdata !== 32'hDEAD_BEEF || dc_done !== 1'b0) begin
        errors++;
        $display("FAIL dc_write_hold[%0d]: got req=%b we=%b addr=%h wdata=%h done=%b want 1 1 00000100 deadbeef 0",
                 i, mem_req, mem_we, mem_addr, mem_wdata, dc_done);
      end
      mem_ready = (i == 3);
      mem_rdata = 32'hFFFF_FFFF;
      step();
    end
    checks++;                                 // cycle k+5
    if (dc_done !== 1'b1 || if_done !== 1'b0 || dc_rdata !== 32'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL dc_write_done: got done=%b/%b rdata=%h mem_req=%b want 1/0 00000000 0",
               dc_done, if_done, dc_rdata, mem_req);
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_contention();
    logic want_dc;
    clear_inputs();
    if_req = 1; if_addr = 32'h200;
    dc_req = 1; dc_addr = 32'h300; dc_we = 0;
    do_reset();
    want_dc = 1'b1;                           // first contention goes to DC
    for (int g = 0; g < 4; g++) begin
      int budget = 6;
      while (mem_req !== 1'b1 && budget > 0) begin
        step();
        budget--;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== (want_dc ? 32'h300 : 32'h200)) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got req=%b addr=%h want 1 %h",
                 g, mem_req, mem_addr, want_dc ? 32'h300 : 32'h200);
      end
      mem_ready = 1; mem_rdata = 32'h1000 + g;
      step();
      mem_ready = 0;
      checks++;
      if (dc_done !== want_dc || if_done !== !want_dc ||
          (want_dc ? dc_rdata : if_rdata) !== 32'h1000 + g) begin
        errors++;
        $display("FAIL contention_done[%0d]: got if=%b dc=%b ifrd=%h dcrd=%h want dc_side=%b rdata=%h",
                 g, if_done, dc_done, if_rdata, dc_rdata, want_dc, 32'h1000 + g);
      end
      want_dc = !want_dc;
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid_mem();
    if_req = 1; if_addr = 32'h80;
    step();                                   // MEM cycle 1 follows
    step();                                   // MEM cycle 2
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got mem_req=%b want 1", mem_req);
    end
    reset = 1;
    step();
    reset = 0;
    checks++;
    if (mem_req !== 1'b0 || if_done !== 1'b0 || dc_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got mem_req=%b done=%b/%b want 0 0/0", mem_req, if_done, dc_done);
    end
    step();                                   // IDLE samples the held request
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80 || if_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_retry: got req=%b addr=%h done=%b want 1 00000080 0", mem_req, mem_addr, if_done);
    end
    mem_ready = 1; mem_rdata = 32'h55;
    step();
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 32'h55) begin
      errors++;
      $display("FAIL abort_served: got done=%b rdata=%h want 1 00000055", if_done, if_rdata);
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_timeout();
    dc_req = 1; dc_we = 0; dc_addr = 32'h10;
    mem_ready = 0; mem_rdata = 32'h1234_5678;
    step();
`ifdef MEM_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (mem_req !== 1'b1 || dc_done !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got req=%b done=%b want 1 0", i, mem_req, dc_done);
      end
      step();
    end
    checks++;
    if (dc_done !== 1'b1 || dc_err !== 1'b1 || dc_rdata !== 32'h0 || mem_req !== 1'b0 || if_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: got done=%b err=%b rdata=%h mem_req=%b want 1 1 00000000 0",
               dc_done, dc_err, dc_rdata, mem_req);
    end
    clear_inputs();
    step();
    checks++;
    if (dc_err !== 1'b0 || dc_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got done=%b err=%b want 0 0", dc_done, dc_err);
    end
`else
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (mem_req !== 1'b1 || dc_done !== 1'b0 || dc_err !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout[%0d]: got req=%b done=%b err=%b want 1 0 0", i, mem_req, dc_done, dc_err);
      end
      step();
    end
    clear_inputs();
    do_reset();
`endif
    step();
  endtask

  // Randomized traffic. The model only knows the external rules: who was
  // requesting when an access started, round-robin on contention, data
  // returned for reads, zero for writes, rdata holding between pulses.
  task automatic test_random();
    logic          exp_last;      // 0=IF, 1=DC
    logic          own;
    logic          in_access;
    logic          own_we;
    int            wait_left;
    int            grants;
    logic [W-1:0]  last_if_rd, last_dc_rd, exp;

    clear_inputs();
    do_reset();
    exp_last   = 1'b0;
    own        = 1'b0;
    own_we     = 1'b0;
    in_access  = 1'b0;
    wait_left  = 0;
    grants     = 0;
    last_if_rd = '0;
    last_dc_rd = '0;
    exp_q.delete();

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        mem_ready = 0;
        in_access = 1'b0;
        checks++;
        if (if_done !== (own == 1'b0) || dc_done !== (own == 1'b1) || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL rnd_done_side@%0d: got if=%b dc=%b mem_req=%b want owner=%b", cyc, if_done, dc_done, mem_req, own);
        end
        checks++;
        if ((own ? dc_rdata : if_rdata) !== exp || if_err !== 1'b0 || dc_err !== 1'b0) begin
          errors++;
          $display("FAIL rnd_rdata@%0d: got %h err=%b/%b want %h", cyc, own ? dc_rdata : if_rdata, if_err, dc_err, exp);
        end
        if (own) last_dc_rd = exp; else last_if_rd = exp;
        // Requester either chains a new request or drops.
        if (own) begin
          dc_req = $urandom_range(0, 1);
          if (dc_req) begin
            dc_we = $urandom_range(0, 1); dc_addr = $urandom; dc_wdata = $urandom;
          end
        end else begin
          if_req = $urandom_range(0, 1);
          if (if_req) if_addr = $urandom;
        end
      end else begin
        checks++;
        if (if_done !== 1'b0 || dc_done !== 1'b0 || if_rdata !== last_if_rd || dc_rdata !== last_dc_rd) begin
          errors++;
          $display("FAIL rnd_quiet@%0d: got done=%b/%b rd=%h/%h want 0/0 %h/%h",
                   cyc, if_done, dc_done, if_rdata, dc_rdata, last_if_rd, last_dc_rd);
        end
        if (mem_req === 1'b1 && !in_access) begin
          if (if_req && dc_req) own = !exp_last;
          else if (dc_req)      own = 1'b1;
          else if (if_req)      own = 1'b0;
          else begin
            checks++;
            errors++;
            $display("FAIL rnd_spurious@%0d: got mem_req=1 want 0 (no requester)", cyc);
          end
          exp_last  = own;
          own_we    = own ? dc_we : 1'b0;
          in_access = 1'b1;
          wait_left = $urandom_range(0, 3);
          grants++;
        end
        if (in_access) begin
          checks++;
          if (mem_req !== 1'b1 || mem_we !== own_we || mem_addr !== (own ? dc_addr : if_addr) ||
              (own && own_we && mem_wdata !== dc_wdata)) begin
            errors++;
            $display("FAIL rnd_mem@%0d: got req=%b we=%b addr=%h wdata=%h want owner=%b we=%b addr=%h",
                     cyc, mem_req, mem_we, mem_addr, mem_wdata, own, own_we, own ? dc_addr : if_addr);
          end
          if (wait_left == 0) begin
            mem_ready = 1;
            mem_rdata = $urandom;
            exp_q.push_back(own_we ? '0 : mem_rdata);
          end else begin
            wait_left--;
            mem_ready = 0;
            mem_rdata = $urandom;
          end
        end else begin
          checks++;
          if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rnd_idle_req@%0d: got mem_req=%b want 0", cyc, mem_req);
          end
        end
      end
      // Idle requesters may raise a new request at any time.
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!dc_req && $urandom_range(0, 2) == 0) begin
        dc_req = 1; dc_we = $urandom_range(0, 1); dc_addr = $urandom; dc_wdata = $urandom;
      end
      step();
    end
    checks++;
    if (grants < 60) begin
      errors++;
      $display("FAIL rnd_throughput: got %0d grants want >= 60", grants);
    end
    clear_inputs();
    do_reset();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_if_read();
    test_dc_write_wait();
    test_contention();
    test_reset_mid_mem();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
